// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
//   arb_state_e : transfer sequencer states
//   GRANT_*     : encoding of the grant observability output
//   STREAK_W    : width of the consecutive-D-grant counter
package mem_arb_pkg;

  localparam int unsigned STREAK_W = 4;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StDReq,
    StDWait,
    StIReq,
    StIWait
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: I-cache miss port, D-cache miss port,
// main-memory port and the grant observability signal.
//   slave  : arbiter view (takes requests, drives memory strobes and stalls)
//   master : environment view (caches + main memory)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned BLK_W  = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [BLK_W-1:0]  i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [BLK_W-1:0]  d_writedata;
  logic [BLK_W-1:0]  d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [BLK_W-1:0]  mem_writedata;
  logic [BLK_W-1:0]  mem_readdata;
  logic              mem_busywait;

  logic [1:0]        grant;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, grant
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, grant
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Combinational priority pick for the memory port.
//   i_req_i  : I-side read pending
//   d_req_i  : D-side read or write pending
//   streak_i : consecutive D grants made while I was pending
//   limit_i  : streak value at which I is forced through
//   grant_o  : GRANT_NONE / GRANT_I / GRANT_D
// D normally wins (older instruction); once the streak reaches the limit a
// pending I request takes the port.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic                i_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  input  logic [STREAK_W-1:0] limit_i,
  output logic [1:0]          grant_o
);

  always_comb begin
    grant_o = GRANT_NONE;
    if (d_req_i && !(i_req_i && (streak_i == limit_i))) begin
      grant_o = GRANT_D;
    end else if (i_req_i) begin
      grant_o = GRANT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory block port between the I-cache miss path (read only)
// and the D-cache miss path (read/write).
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave view of mem_port_arbiter_if (I port, D port, memory port, grant)
// Each transfer runs IDLE -> X_REQ -> X_WAIT (until mem_busywait low) -> IDLE.
// Busywait per side is request & ~done, so a stall starts in the request cycle
// and is released combinationally in the done cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned BLK_W        = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STREAK_W-1:0] Limit = STREAK_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [1:0]          grant_nxt;
  logic                d_req;
  logic                d_xfer, i_xfer;
  logic                d_done, i_done;

  // Capture registers: memory is driven only from these.
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLK_W-1:0]    wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  assign d_req = bus.d_read | bus.d_write;

  mem_arb_prio u_prio (
    .i_req_i  (bus.i_read),
    .d_req_i  (d_req),
    .streak_i (streak_q),
    .limit_i  (Limit),
    .grant_o  (grant_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_nxt == GRANT_D) begin
          state_d = StDReq;
        end else if (grant_nxt == GRANT_I) begin
          state_d = StIReq;
        end
      end
      StDReq:  state_d = StDWait;
      StDWait: if (!bus.mem_busywait) state_d = StIdle;
      StIReq:  state_d = StIWait;
      StIWait: if (!bus.mem_busywait) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant capture and starvation streak, both only updated while arbitrating.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    streak_d = streak_q;
    if (state_q == StIdle) begin
      if (grant_nxt == GRANT_D) begin
        addr_d  = bus.d_address;
        wdata_d = bus.d_writedata;
        write_d = bus.d_write;  // write wins on an illegal read+write
      end else if (grant_nxt == GRANT_I) begin
        addr_d  = bus.i_address;
        wdata_d = '0;
        write_d = 1'b0;
      end

      if ((grant_nxt == GRANT_I) || !bus.i_read) begin
        streak_d = '0;
      end else if ((grant_nxt == GRANT_D) && (streak_q != Limit)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      streak_q <= streak_d;
    end
  end

  // Output decode
  always_comb begin
    d_xfer = (state_q == StDReq) || (state_q == StDWait);
    i_xfer = (state_q == StIReq) || (state_q == StIWait);
    d_done = (state_q == StDWait) && !bus.mem_busywait;
    i_done = (state_q == StIWait) && !bus.mem_busywait;

    bus.mem_read      = (d_xfer || i_xfer) && !write_q;
    bus.mem_write     = (d_xfer || i_xfer) && write_q;
    bus.mem_address   = addr_q;
    bus.mem_writedata = wdata_q;

    if (d_xfer) begin
      bus.grant = GRANT_D;
    end else if (i_xfer) begin
      bus.grant = GRANT_I;
    end else begin
      bus.grant = GRANT_NONE;
    end

    bus.i_busywait = bus.i_read && !i_done;
    bus.d_busywait = d_req && !d_done;
    bus.i_readdata = i_done ? bus.mem_readdata : '0;
    bus.d_readdata = d_done ? bus.mem_readdata : '0;
  end

  d_dir_excl: assert property (@(posedge clk) disable iff (!rst) !(bus.d_read && bus.d_write))
    else $error("d_read and d_write asserted together");

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 28;
  localparam int unsigned BW = 128;

  typedef struct {
    logic [1:0]    grant;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  exp_t exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(AW), .BLK_W(BW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .BLK_W(BW), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Main-memory model: busy for mem_lat cycles starting the cycle after X_REQ.
  logic [BW-1:0] mem_data = '0;
  int unsigned   mem_lat  = 0;
  logic          mem_act  = 1'b0;
  int unsigned   mem_cnt  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_act <= 1'b0;
      mem_cnt <= 0;
    end else if (!mem_act) begin
      if (bus.mem_read || bus.mem_write) begin
        mem_act <= 1'b1;
        mem_cnt <= mem_lat;
      end
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end else begin
      mem_act <= 1'b0;
    end
  end

  assign bus.mem_busywait = mem_act && (mem_cnt != 0);
  assign bus.mem_readdata = mem_data;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] wd);
    exp_t e;
    e.grant = g;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busywait high from the current cycle; stops in release cycle.
  task automatic wait_release(input bit is_d, output int n, output logic last_mbw);
    n = 0;
    last_mbw = 1'bx;
    while (((is_d ? bus.d_busywait : bus.i_busywait) === 1'b1) && (n < 50)) begin
      n++;
      last_mbw = bus.mem_busywait;
      tick();
    end
  endtask

  // Grant scoreboard: every new grant is checked against the next expected transfer;
  // during a transfer the memory address must hold the captured value.
  logic [1:0]    prev_grant = GRANT_NONE;
  logic [AW-1:0] cur_addr   = '0;

  always @(negedge clk) begin
    exp_t e;
    if ((bus.grant != GRANT_NONE) && (prev_grant == GRANT_NONE)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", bus.grant, GRANT_NONE);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", bus.grant, e.grant);
        chk("sb_mem_write", bus.mem_write, e.wr);
        chk("sb_mem_read", bus.mem_read, !e.wr);
        chk("sb_mem_address", bus.mem_address, e.addr);
        if (e.wr) chk("sb_mem_writedata", bus.mem_writedata, e.wdata);
        cur_addr = e.addr;
      end
    end else if (bus.grant != GRANT_NONE) begin
      chk("addr_stable", bus.mem_address, cur_addr);
    end
    prev_grant = bus.grant;
  end

  task automatic zero_lat_run(input bit is_d, input logic [AW-1:0] a, output int rel,
                              output int rd_cnt);
    rel = -1;
    rd_cnt = 0;
    if (is_d) begin
      bus.d_read = 1'b1;
      bus.d_address = a;
    end else begin
      bus.i_read = 1'b1;
      bus.i_address = a;
    end
    #1;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_read) rd_cnt++;
      if ((rel < 0) && !(is_d ? bus.d_busywait : bus.i_busywait)) begin
        rel = k;
        chk("zl_rdata", is_d ? bus.d_readdata : bus.i_readdata, mem_data);
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    int n;
    int ilow;
    int dcount;
    int rel;
    int rd_cnt;
    bit igot;
    logic mbw;

    bus.i_read = 1'b0;
    bus.i_address = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_address = '0;
    bus.d_writedata = '0;

    // Reset values
    #12;
    chk("rst_grant", bus.grant, GRANT_NONE);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_writedata", bus.mem_writedata, 0);
    chk("rst_i_readdata", bus.i_readdata, 0);
    chk("rst_d_readdata", bus.d_readdata, 0);
    bus.i_read = 1'b1;
    bus.d_write = 1'b1;
    #1;
    chk("rst_i_bw_follows_req", bus.i_busywait, 1);
    chk("rst_d_bw_follows_req", bus.d_busywait, 1);
    bus.i_read = 1'b0;
    bus.d_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Lone I read, memory busy 4 cycles
    mem_lat = 4;
    mem_data = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
    push(GRANT_I, 1'b0, 28'h0000010, '0);
    bus.i_read = 1'b1;
    bus.i_address = 28'h0000010;
    #1;
    chk("t1_bw_same_cycle", bus.i_busywait, 1);
    chk("t1_grant_c0", bus.grant, GRANT_NONE);
    tick();
    chk("t1_grant_c1", bus.grant, GRANT_I);
    wait_release(1'b0, n, mbw);
    chk("t1_released", bus.i_busywait, 0);
    chk("t1_mbw_prev_high", mbw, 1);
    chk("t1_mbw_low_at_release", bus.mem_busywait, 0);
    chk("t1_rdata", bus.i_readdata, mem_data);
    chk("t1_stall_cycles", n + 1, 6);
    bus.i_read = 1'b0;
    tick();

    // I read and D write raised together: D first
    mem_lat = 2;
    mem_data = 128'h55AA55AA_11112222_33334444_55556666;
    push(GRANT_D, 1'b1, 28'h0000020, 128'hCAFEF00D_00000000_12345678_9ABCDEF0);
    push(GRANT_I, 1'b0, 28'h0000030, '0);
    bus.d_write = 1'b1;
    bus.d_address = 28'h0000020;
    bus.d_writedata = 128'hCAFEF00D_00000000_12345678_9ABCDEF0;
    bus.i_read = 1'b1;
    bus.i_address = 28'h0000030;
    #1;
    n = 0;
    ilow = 0;
    while (bus.d_busywait && (n < 50)) begin
      if (!bus.i_busywait) ilow++;
      n++;
      tick();
    end
    chk("t2_d_released", bus.d_busywait, 0);
    chk("t2_d_stall", n, 4);
    chk("t2_i_held_during_d", ilow, 0);
    chk("t2_i_bw_in_d_done", bus.i_busywait, 1);
    bus.d_write = 1'b0;
    tick();
    chk("t2_idle_grant", bus.grant, GRANT_NONE);
    tick();
    chk("t2_i_granted", bus.grant, GRANT_I);
    wait_release(1'b0, n, mbw);
    chk("t2_i_released", bus.i_busywait, 0);
    chk("t2_i_rdata", bus.i_readdata, mem_data);
    bus.i_read = 1'b0;
    tick();

    // Anti-starvation: 4 D grants, 1 I grant, then D again
    mem_lat = 1;
    for (int k = 0; k < 4; k++) push(GRANT_D, 1'b0, 28'h0000050, '0);
    push(GRANT_I, 1'b0, 28'h0000040, '0);
    push(GRANT_D, 1'b0, 28'h0000050, '0);
    bus.i_read = 1'b1;
    bus.i_address = 28'h0000040;
    bus.d_read = 1'b1;
    bus.d_address = 28'h0000050;
    dcount = 0;
    igot = 1'b0;
    for (int cyc = 0; (cyc < 200) && (dcount < 5); cyc++) begin
      tick();
      if (!bus.d_busywait) begin
        dcount++;
        chk("t3_d_rdata", bus.d_readdata, mem_data);
        if (dcount == 5) bus.d_read = 1'b0;
      end
      if (!igot && !bus.i_busywait) begin
        igot = 1'b1;
        chk("t3_i_after_4_d", dcount, 4);
        chk("t3_i_rdata", bus.i_readdata, mem_data);
        bus.i_read = 1'b0;
      end
    end
    chk("t3_d_count", dcount, 5);
    chk("t3_i_served", igot, 1);
    tick();

    // Zero-latency memory
    mem_lat = 0;
    mem_data = 128'h0BADC0DE_FEEDFACE_00000001_00000002;
    push(GRANT_I, 1'b0, 28'h0000060, '0);
    zero_lat_run(1'b0, 28'h0000060, rel, rd_cnt);
    chk("t4_i_release_cycle", rel, 2);
    chk("t4_i_mem_read_cycles", rd_cnt, 2);
    push(GRANT_D, 1'b0, 28'h0000061, '0);
    zero_lat_run(1'b1, 28'h0000061, rel, rd_cnt);
    chk("t4_d_release_cycle", rel, 2);
    chk("t4_d_mem_read_cycles", rd_cnt, 2);

    // Reset during D_WAIT
    mem_lat = 5;
    push(GRANT_D, 1'b1, 28'h0000070, 128'h77777777_88888888_99999999_AAAAAAAA);
    push(GRANT_D, 1'b1, 28'h0000070, 128'h77777777_88888888_99999999_AAAAAAAA);
    push(GRANT_I, 1'b0, 28'h0000080, '0);
    bus.d_write = 1'b1;
    bus.d_address = 28'h0000070;
    bus.d_writedata = 128'h77777777_88888888_99999999_AAAAAAAA;
    bus.i_read = 1'b1;
    bus.i_address = 28'h0000080;
    tick();
    tick();
    chk("t5_mem_write_in_wait", bus.mem_write, 1);
    chk("t5_streak_before", dut.streak_q, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_mem_write_async", bus.mem_write, 0);
    chk("t5_grant_async", bus.grant, GRANT_NONE);
    chk("t5_streak_cleared", dut.streak_q, 0);
    chk("t5_mem_address_cleared", bus.mem_address, 0);
    chk("t5_d_bw_in_reset", bus.d_busywait, 1);
    chk("t5_i_bw_in_reset", bus.i_busywait, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_release(1'b1, n, mbw);
    chk("t5_d_released", bus.d_busywait, 0);
    bus.d_write = 1'b0;
    wait_release(1'b0, n, mbw);
    chk("t5_i_released", bus.i_busywait, 0);
    bus.i_read = 1'b0;
    tick();

    // d_address changes mid-transfer
    mem_lat = 3;
    push(GRANT_D, 1'b0, 28'h0000090, '0);
    bus.d_read = 1'b1;
    bus.d_address = 28'h0000090;
    tick();
    tick();
    bus.d_address = 28'h0ABCDEF;
    #1;
    chk("t6_addr_held", bus.mem_address, 28'h0000090);
    wait_release(1'b1, n, mbw);
    chk("t6_d_released", bus.d_busywait, 0);
    chk("t6_d_rdata", bus.d_readdata, mem_data);
    bus.d_read = 1'b0;

    repeat (3) tick();
    chk("sb_all_grants_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one main-memory port between the instruction-cache miss path (I, read-only) and the data-cache miss path (D, read/write).
- Sequences each block transfer and returns a per-requester busywait. The pipeline ORs the busywaits into the stall that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- D has priority because it belongs to the older instruction. A streak counter guarantees I is not starved.

Parameters:
ADDR_W, 28, block-address width (byte address >> 4)
BLK_W, 128, block data width
STARVE_LIMIT, 4, consecutive D grants allowed while I is pending; range 1..15

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
i_read  in  1  I-side block read request; level, held until i_busywait low
i_address  in  ADDR_W  I-side block address
i_readdata  out  BLK_W  I-side returned block; valid only in I done cycle
i_busywait  out  1  I-side stall
d_read  in  1  D-side block read request; level
d_write  in  1  D-side block write request; level; never asserted together with d_read
d_address  in  ADDR_W  D-side block address
d_writedata  in  BLK_W  D-side write block
d_readdata  out  BLK_W  D-side returned block; valid only in D done cycle
d_busywait  out  1  D-side stall
mem_read  out  1  main-memory read strobe
mem_write  out  1  main-memory write strobe
mem_address  out  ADDR_W  main-memory block address
mem_writedata  out  BLK_W  main-memory write block
mem_readdata  in  BLK_W  main-memory read block
mem_busywait  in  1  main memory busy; falls in the cycle the transfer completes
grant  out  2  observability: 00 none, 01 I, 10 D

Behaviour:
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. All are registered; outputs are decoded from state.
- IDLE transitions, evaluated on the rising edge:
  - d_req = d_read|d_write.
  - If d_req and not (i_read and streak==STARVE_LIMIT) -> D_REQ.
  - Else if i_read -> I_REQ.
  - Else stay in IDLE.
- Grant capture on entry to X_REQ: address, direction and write data are registered from the winning requester. mem_* outputs are driven from these registers only, so requester changes mid-transfer do not reach memory.
- X_REQ:
  - mem_read or mem_write is asserted, grant = X.
  - Unconditional move to X_WAIT; memory is given one cycle to raise mem_busywait.
- X_WAIT:
  - Strobes stay asserted.
  - While mem_busywait==1, stay in X_WAIT.
  - When mem_busywait==0, this is the done cycle: X_busywait = 0 combinationally, X_readdata = mem_readdata combinationally, next state IDLE.
  - Strobes drop on the following edge.
- Busywait function: X_busywait = X_request & ~X_done, where X_done is high only in the X done cycle. This gives:
  - A new request stalls in the same cycle.
  - Minimum request-to-release latency is 3 cycles (IDLE, X_REQ, X_WAIT with mem_busywait already 0).
- Back-to-back: the IDLE cycle after a done cycle re-arbitrates. A requester still asserting in that cycle is treated as a new request; the caches must drop their request after a done cycle.
- Streak counter (4-bit):
  - Increments on each D grant made while i_read==1.
  - Clears on any I grant, and clears in IDLE when i_read==0.
  - Saturates at STARVE_LIMIT.
- Simultaneous I and D in IDLE: D wins unless streak==STARVE_LIMIT.
- d_read and d_write both high is illegal. Write wins if it occurs; an assertion flags it in simulation.
- Reset (rst==0), at any time including mid-transfer:
  - State goes to IDLE immediately; streak = 0.
  - mem_read = mem_write = 0, grant = 00.
  - mem_address and mem_writedata = 0; i_readdata and d_readdata = 0.
  - i_busywait = i_read and d_busywait = d_read|d_write, because done is never asserted during reset.
  - An aborted memory transfer is not replayed; the requester's still-held request is re-arbitrated after reset release.

Decomposition:
- Package mem_arb_pkg holds the state enum (IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT), the GRANT_NONE/I/D constants and a STREAK_W=4 localparam.
- One sub-module, mem_arb_prio: a combinational priority pick of (i_read, d_req, streak, limit) -> next grant, unit-testable alone.
- FSM, capture registers and streak counter stay in the top module.

Test Plan:
- Lone I read, addr 0x0000010, memory busy for 4 cycles, returns 0xDEADBEEF_...:
  - grant goes 01 one cycle after the request.
  - i_busywait falls exactly in the cycle mem_busywait falls, with i_readdata equal to the memory data.
  - Total stall is 6 cycles.
- I read and D write at addr 0x0000020 raised in the same cycle:
  - D is granted first; mem_write=1 and mem_writedata equal d_writedata.
  - I is granted in the first IDLE after D done.
  - i_busywait stays high throughout the D transfer.
- Anti-starvation with i_read held and D re-requesting immediately after each done, STARVE_LIMIT=4:
  - Exactly 4 D grants occur, then 1 I grant, then D resumes.
- Zero-latency memory (mem_busywait never high):
  - Each request is released in its 3rd cycle.
  - mem_read is high for exactly 2 cycles.
- rst driven low in D_WAIT:
  - mem_write drops asynchronously before the next edge; grant=00; streak=0.
  - After release with d_write still held, D is re-granted with the same address.
- Requester changes d_address during D_WAIT:
  - mem_address stays at the captured value for the whole transfer.
